// File: rtl/pipe_pc_ctrl.sv
// Next-PC selection and pipeline control: redirects, stalls (single and multi-cycle),
// interrupt entry with a two-cycle wrong-path kill, and return from handler.
module pipe_pc_ctrl #(
    parameter logic [31:0] EXC_VEC = 32'h00000008
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic [31:0] pc,
    output logic [31:0] npc,
    output logic        wpc,
    output logic        flush,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        load_use,
    input  logic        mdu_start,
    input  logic [5:0]  mdu_cycles,
    input  logic        irq,
    input  logic        irq_en,
    input  logic        eret,
    output logic [31:0] epc,
    output logic [1:0]  state,
    output logic        in_handler
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MSTALL = 2'd1,
        EXC    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] epc_q, epc_d;
    logic        in_handler_q, in_handler_d;

    logic        irq_take;
    logic [31:0] pc_seq;

    assign irq_take = irq & irq_en & ~in_handler_q;
    assign pc_seq   = pc + 32'd4;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= RUN;
            cnt_q        <= 6'd0;
            epc_q        <= 32'd0;
            in_handler_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            epc_q        <= epc_d;
            in_handler_q <= in_handler_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        epc_d        = epc_q;
        in_handler_d = in_handler_q;
        npc          = pc;
        wpc          = 1'b0;
        flush        = 1'b0;

        unique case (state_q)
            RUN: begin
                if (irq_take) begin
                    npc          = EXC_VEC;
                    wpc          = 1'b1;
                    flush        = 1'b1;
                    epc_d        = pc;
                    in_handler_d = 1'b1;
                    state_d      = EXC;
                end else if (eret) begin
                    npc          = epc_q;
                    wpc          = 1'b1;
                    flush        = 1'b1;
                    in_handler_d = 1'b0;
                end else if (jmp) begin
                    npc   = jmp_target;
                    wpc   = 1'b1;
                    flush = 1'b1;
                end else if (br_taken) begin
                    npc   = br_target;
                    wpc   = 1'b1;
                    flush = 1'b1;
                end else if (mdu_start && (mdu_cycles != 6'd0)) begin
                    // The start cycle is itself the first stall cycle.
                    cnt_d = mdu_cycles - 6'd1;
                    if (mdu_cycles != 6'd1) begin
                        state_d = MSTALL;
                    end
                end else if (load_use) begin
                    npc = pc;
                end else begin
                    npc = pc_seq;
                    wpc = 1'b1;
                end
            end
            MSTALL: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q <= 6'd1) begin
                    cnt_d   = 6'd0;
                    state_d = RUN;
                end
            end
            EXC: begin
                // Kill the second instruction fetched down the pre-interrupt path.
                npc     = pc_seq;
                wpc     = 1'b1;
                flush   = 1'b1;
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (!clrn) begin
            npc   = 32'd0;
            wpc   = 1'b0;
            flush = 1'b1;
        end
    end

    assign epc        = epc_q;
    assign state      = state_q;
    assign in_handler = in_handler_q;

endmodule

// File: tb/tb_pipe_pc_ctrl.sv
// Directed bench for pipe_pc_ctrl: each task drives one scenario and checks inline
// against hand-computed values.
module tb_pipe_pc_ctrl;

    logic        clk;
    logic        clrn;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        wpc;
    logic        flush;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        load_use;
    logic        mdu_start;
    logic [5:0]  mdu_cycles;
    logic        irq;
    logic        irq_en;
    logic        eret;
    logic [31:0] epc;
    logic [1:0]  state;
    logic        in_handler;

    int n_cmp;
    int n_fail;

    pipe_pc_ctrl #(.EXC_VEC(32'h00000008)) dut (
        .clk(clk), .clrn(clrn), .pc(pc), .npc(npc), .wpc(wpc), .flush(flush),
        .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
        .load_use(load_use), .mdu_start(mdu_start), .mdu_cycles(mdu_cycles),
        .irq(irq), .irq_en(irq_en), .eret(eret), .epc(epc), .state(state),
        .in_handler(in_handler)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        br_taken = 0; br_target = 32'h0; jmp = 0; jmp_target = 32'h0;
        load_use = 0; mdu_start = 0; mdu_cycles = 6'd0;
        irq = 0; irq_en = 0; eret = 0;
    endtask

    task automatic test_reset();
        idle();
        pc = 32'h0;
        clrn = 0;
        tick();
        tick();
        n_cmp++; if (state !== 2'd0) begin $display("FAIL rst_state got %0d want 0", state); n_fail++; end
        n_cmp++; if (epc !== 32'h0) begin $display("FAIL rst_epc got %h want 0", epc); n_fail++; end
        n_cmp++; if (in_handler !== 1'b0) begin $display("FAIL rst_inh got %b want 0", in_handler); n_fail++; end
        n_cmp++; if (wpc !== 1'b0) begin $display("FAIL rst_wpc got %b want 0", wpc); n_fail++; end
        n_cmp++; if (flush !== 1'b1) begin $display("FAIL rst_flush got %b want 1", flush); n_fail++; end
        n_cmp++; if (npc !== 32'h0) begin $display("FAIL rst_npc got %h want 0", npc); n_fail++; end
        clrn = 1;
        #1;
        n_cmp++; if (npc !== 32'h4 || wpc !== 1'b1 || flush !== 1'b0) begin
            $display("FAIL rst_release npc=%h wpc=%b flush=%b want 4/1/0", npc, wpc, flush); n_fail++; end
        tick();
    endtask

    task automatic test_sequential();
        idle();
        pc = 32'h100;
        #1;
        n_cmp++; if (npc !== 32'h104 || wpc !== 1'b1 || flush !== 1'b0) begin
            $display("FAIL seq_100 npc=%h wpc=%b flush=%b want 104/1/0", npc, wpc, flush); n_fail++; end
        tick();
        pc = 32'hFFFFFFFC;
        #1;
        n_cmp++; if (npc !== 32'h0 || wpc !== 1'b1) begin
            $display("FAIL seq_wrap npc=%h wpc=%b want 0/1", npc, wpc); n_fail++; end
        tick();
    endtask

    task automatic test_load_use();
        idle();
        pc = 32'h40; load_use = 1;
        #1;
        n_cmp++; if (wpc !== 1'b0 || flush !== 1'b0 || npc !== 32'h40) begin
            $display("FAIL lu_stall npc=%h wpc=%b flush=%b want 40/0/0", npc, wpc, flush); n_fail++; end
        tick();
        load_use = 0;
        #1;
        n_cmp++; if (npc !== 32'h44 || wpc !== 1'b1 || state !== 2'd0) begin
            $display("FAIL lu_resume npc=%h wpc=%b state=%0d want 44/1/0", npc, wpc, state); n_fail++; end
        tick();
    endtask

    task automatic test_mdu_stall();
        idle();
        pc = 32'h50; mdu_start = 1; mdu_cycles = 6'd3;
        #1;
        n_cmp++; if (wpc !== 1'b0 || npc !== 32'h50) begin
            $display("FAIL mdu_c1 npc=%h wpc=%b want 50/0", npc, wpc); n_fail++; end
        tick();
        mdu_start = 0; mdu_cycles = 6'd0; irq = 1; irq_en = 1; jmp = 1; jmp_target = 32'h900;
        #1;
        n_cmp++; if (state !== 2'd1 || wpc !== 1'b0 || flush !== 1'b0 || npc !== 32'h50) begin
            $display("FAIL mdu_c2 state=%0d wpc=%b flush=%b npc=%h want 1/0/0/50", state, wpc, flush, npc); n_fail++; end
        tick();
        #1;
        n_cmp++; if (state !== 2'd1 || wpc !== 1'b0) begin
            $display("FAIL mdu_c3 state=%0d wpc=%b want 1/0", state, wpc); n_fail++; end
        tick();
        jmp = 0;
        #1;
        n_cmp++; if (state !== 2'd0 || npc !== 32'h8 || wpc !== 1'b1 || flush !== 1'b1) begin
            $display("FAIL mdu_irq state=%0d npc=%h wpc=%b flush=%b want 0/8/1/1", state, npc, wpc, flush); n_fail++; end
        tick();
        irq = 0;
        n_cmp++; if (state !== 2'd2 || epc !== 32'h50 || in_handler !== 1'b1) begin
            $display("FAIL mdu_exc state=%0d epc=%h inh=%b want 2/50/1", state, epc, in_handler); n_fail++; end
        pc = 32'h8;
        tick();
        eret = 1; pc = 32'hC;
        tick();
        eret = 0;
        n_cmp++; if (in_handler !== 1'b0) begin $display("FAIL mdu_eret inh got %b want 0", in_handler); n_fail++; end
    endtask

    task automatic test_mdu_edge();
        idle();
        pc = 32'h60; mdu_start = 1; mdu_cycles = 6'd0; load_use = 1;
        #1;
        n_cmp++; if (wpc !== 1'b0 || npc !== 32'h60) begin
            $display("FAIL mdu0_lu npc=%h wpc=%b want 60/0", npc, wpc); n_fail++; end
        load_use = 0;
        #1;
        n_cmp++; if (wpc !== 1'b1 || npc !== 32'h64) begin
            $display("FAIL mdu0_seq npc=%h wpc=%b want 64/1", npc, wpc); n_fail++; end
        tick();
        n_cmp++; if (state !== 2'd0) begin $display("FAIL mdu0_state got %0d want 0", state); n_fail++; end
        mdu_cycles = 6'd1;
        #1;
        n_cmp++; if (wpc !== 1'b0) begin $display("FAIL mdu1_stall wpc got %b want 0", wpc); n_fail++; end
        tick();
        mdu_start = 0; mdu_cycles = 6'd0;
        #1;
        n_cmp++; if (state !== 2'd0 || wpc !== 1'b1 || npc !== 32'h64) begin
            $display("FAIL mdu1_resume state=%0d wpc=%b npc=%h want 0/1/64", state, wpc, npc); n_fail++; end
        tick();
    endtask

    task automatic test_interrupt();
        idle();
        pc = 32'h200; irq = 1; irq_en = 0;
        #1;
        n_cmp++; if (npc !== 32'h204 || flush !== 1'b0) begin
            $display("FAIL irq_masked npc=%h flush=%b want 204/0", npc, flush); n_fail++; end
        irq_en = 1;
        #1;
        n_cmp++; if (npc !== 32'h8 || wpc !== 1'b1 || flush !== 1'b1) begin
            $display("FAIL irq_take npc=%h wpc=%b flush=%b want 8/1/1", npc, wpc, flush); n_fail++; end
        tick();
        pc = 32'h8;
        #1;
        n_cmp++; if (state !== 2'd2 || epc !== 32'h200 || in_handler !== 1'b1) begin
            $display("FAIL irq_regs state=%0d epc=%h inh=%b want 2/200/1", state, epc, in_handler); n_fail++; end
        n_cmp++; if (flush !== 1'b1 || wpc !== 1'b1 || npc !== 32'hC) begin
            $display("FAIL irq_exc flush=%b wpc=%b npc=%h want 1/1/c", flush, wpc, npc); n_fail++; end
        tick();
        pc = 32'hC;
        #1;
        n_cmp++; if (state !== 2'd0 || npc !== 32'h10 || flush !== 1'b0) begin
            $display("FAIL irq_noreentry state=%0d npc=%h flush=%b want 0/10/0", state, npc, flush); n_fail++; end
        tick();
        irq = 0; eret = 1; pc = 32'h10;
        #1;
        n_cmp++; if (npc !== 32'h200 || flush !== 1'b1 || wpc !== 1'b1) begin
            $display("FAIL eret_npc npc=%h flush=%b wpc=%b want 200/1/1", npc, flush, wpc); n_fail++; end
        tick();
        n_cmp++; if (in_handler !== 1'b0) begin $display("FAIL eret_inh got %b want 0", in_handler); n_fail++; end
        pc = 32'h200;
        #1;
        n_cmp++; if (npc !== 32'h200 || flush !== 1'b1) begin
            $display("FAIL eret_outside npc=%h flush=%b want 200/1", npc, flush); n_fail++; end
        tick();
        eret = 0;
    endtask

    task automatic test_priority();
        idle();
        pc = 32'h80; jmp = 1; jmp_target = 32'h300; br_taken = 1; br_target = 32'h400;
        #1;
        n_cmp++; if (npc !== 32'h300 || flush !== 1'b1 || wpc !== 1'b1) begin
            $display("FAIL prio_jmp_br npc=%h flush=%b wpc=%b want 300/1/1", npc, flush, wpc); n_fail++; end
        jmp = 0;
        #1;
        n_cmp++; if (npc !== 32'h400 || flush !== 1'b1) begin
            $display("FAIL prio_br npc=%h flush=%b want 400/1", npc, flush); n_fail++; end
        br_taken = 0; jmp = 1; eret = 1;
        #1;
        n_cmp++; if (npc !== 32'h200) begin $display("FAIL prio_eret_jmp npc=%h want 200", npc); n_fail++; end
        eret = 0; load_use = 1; mdu_start = 1; mdu_cycles = 6'd4;
        #1;
        n_cmp++; if (npc !== 32'h300 || wpc !== 1'b1) begin
            $display("FAIL prio_jmp_stall npc=%h wpc=%b want 300/1", npc, wpc); n_fail++; end
        load_use = 0; mdu_start = 0; mdu_cycles = 6'd0;
        pc = 32'h124; irq = 1; irq_en = 1;
        #1;
        n_cmp++; if (npc !== 32'h8 || flush !== 1'b1) begin
            $display("FAIL prio_irq_jmp npc=%h flush=%b want 8/1", npc, flush); n_fail++; end
        tick();
        irq = 0; jmp = 0;
        n_cmp++; if (epc !== 32'h124 || state !== 2'd2) begin
            $display("FAIL prio_irq_epc epc=%h state=%0d want 124/2", epc, state); n_fail++; end
        pc = 32'h8;
        tick();
        eret = 1;
        tick();
        eret = 0;
    endtask

    task automatic test_reset_mid();
        idle();
        pc = 32'h500; mdu_start = 1; mdu_cycles = 6'd6;
        tick();
        mdu_start = 0; mdu_cycles = 6'd0;
        n_cmp++; if (state !== 2'd1) begin $display("FAIL rmid_mstall state got %0d want 1", state); n_fail++; end
        clrn = 0;
        #1;
        n_cmp++; if (state !== 2'd0 || wpc !== 1'b0 || flush !== 1'b1 || npc !== 32'h0) begin
            $display("FAIL rmid_hold state=%0d wpc=%b flush=%b npc=%h want 0/0/1/0", state, wpc, flush, npc); n_fail++; end
        tick();
        clrn = 1; pc = 32'h0;
        #1;
        n_cmp++; if (npc !== 32'h4 || wpc !== 1'b1 || flush !== 1'b0) begin
            $display("FAIL rmid_release npc=%h wpc=%b flush=%b want 4/1/0", npc, wpc, flush); n_fail++; end
        tick();
        pc = 32'h4;
        #1;
        n_cmp++; if (state !== 2'd0 || wpc !== 1'b1 || npc !== 32'h8) begin
            $display("FAIL rmid_nostall state=%0d wpc=%b npc=%h want 0/1/8", state, wpc, npc); n_fail++; end
        irq = 1; irq_en = 1; pc = 32'h700;
        tick();
        irq = 0;
        n_cmp++; if (state !== 2'd2) begin $display("FAIL rexc_enter state got %0d want 2", state); n_fail++; end
        clrn = 0;
        #1;
        n_cmp++; if (state !== 2'd0 || in_handler !== 1'b0 || epc !== 32'h0) begin
            $display("FAIL rexc_abort state=%0d inh=%b epc=%h want 0/0/0", state, in_handler, epc); n_fail++; end
        tick();
        clrn = 1;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        idle();
        pc = 32'h0;
        clrn = 0;
        test_reset();
        test_sequential();
        test_load_use();
        test_mdu_stall();
        test_mdu_edge();
        test_interrupt();
        test_priority();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
